// File: rtl/regfile_rat_mp_pkg.sv
// ============================================================================
// Module   : regfile_rat_mp_pkg
// Brief    : Shared widths and constants for the multi-port regfile / RAT.
//            Optional feature macro: RF_COMMIT_BYPASS_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_rat_mp_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int REG_NUM_DEF   = 32;
  localparam int REG_W_DEF     = 5;
  localparam int ROB_W_DEF     = 4;
  localparam int RD_PORTS_DEF  = 2;
  localparam int CMT_PORTS_DEF = 2;

  localparam logic [XLEN_DEF-1:0]  ZERO_WORD = '0;
  localparam logic [ROB_W_DEF-1:0] ZERO_ROB  = '0;
  localparam logic                 TRUE      = 1'b1;
  localparam logic                 FALSE     = 1'b0;
endpackage

`default_nettype wire

// File: rtl/regfile_rat_mp_rf_read_port.sv
// ============================================================================
// Module   : rf_read_port
// Brief    : One decoder read port: array lookup, x0 masking, optional
//            same-cycle commit bypass (RF_COMMIT_BYPASS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_read_port
  import regfile_rat_mp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int CMT_PORTS = CMT_PORTS_DEF
) (
  input  logic [REG_W-1:0]           rd_reg,
  input  logic [XLEN-1:0]            values [REG_NUM],
  input  logic [ROB_W-1:0]           rename [REG_NUM],
  input  logic [REG_NUM-1:0]         busy,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic [CMT_PORTS-1:0]       cmt_eff,
  input  logic [CMT_PORTS*REG_W-1:0] cmt_reg,
  input  logic [CMT_PORTS*ROB_W-1:0] cmt_rob,
  input  logic [CMT_PORTS*XLEN-1:0]  cmt_value,
  input  logic                       alloc_eff,
  input  logic [REG_W-1:0]           alloc_reg,
`endif
  output logic [XLEN-1:0]            rd_value,
  output logic [ROB_W-1:0]           rd_rob,
  output logic                       rd_busy
);

  always_comb begin
    rd_value = '0;
    rd_rob   = '0;
    rd_busy  = FALSE;
    if (rd_reg != '0) begin
      rd_value = values[rd_reg];
      rd_rob   = rename[rd_reg];
      rd_busy  = busy[rd_reg];
`ifdef RF_COMMIT_BYPASS_EN
      // Ascending scan so the youngest matching commit port wins the value.
      for (int j = 0; j < CMT_PORTS; j++) begin
        if (cmt_eff[j] && (cmt_reg[j*REG_W +: REG_W] == rd_reg)) begin
          rd_value = cmt_value[j*XLEN +: XLEN];
          if ((cmt_rob[j*ROB_W +: ROB_W] == rename[rd_reg]) &&
              !(alloc_eff && (alloc_reg == rd_reg)))
            rd_busy = FALSE;
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_rat_mp.sv
// ============================================================================
// Module   : regfile_rat_mp
// Brief    : Architectural register file with rename table, RD_PORTS reads,
//            one allocation and CMT_PORTS in-order commits per cycle.
//            Optional feature macro: RF_COMMIT_BYPASS_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_rat_mp
  import regfile_rat_mp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int RD_PORTS  = RD_PORTS_DEF,
  parameter int CMT_PORTS = CMT_PORTS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic [RD_PORTS*REG_W-1:0]  rd_reg,
  output logic [RD_PORTS*XLEN-1:0]   rd_value,
  output logic [RD_PORTS*ROB_W-1:0]  rd_rob,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       alloc_en,
  input  logic [REG_W-1:0]           alloc_reg,
  input  logic [ROB_W-1:0]           alloc_rob,
  input  logic [CMT_PORTS-1:0]       cmt_en,
  input  logic [CMT_PORTS*REG_W-1:0] cmt_reg,
  input  logic [CMT_PORTS*ROB_W-1:0] cmt_rob,
  input  logic [CMT_PORTS*XLEN-1:0]  cmt_value,
  input  logic                       flush,
  output logic [REG_W:0]             busy_cnt
);

  logic [XLEN-1:0]    values    [REG_NUM];
  logic [ROB_W-1:0]   rename    [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [XLEN-1:0]    values_nx [REG_NUM];
  logic [ROB_W-1:0]   rename_nx [REG_NUM];
  logic [REG_NUM-1:0] busy_nx;
  logic [CMT_PORTS-1:0] cmt_eff;
  logic                 alloc_eff;

  always_comb begin
    for (int j = 0; j < CMT_PORTS; j++)
      cmt_eff[j] = rdy && cmt_en[j] && (cmt_reg[j*REG_W +: REG_W] != '0);
    alloc_eff = rdy && alloc_en && (alloc_reg != '0);
  end

  // Priority, lowest to highest: commits (ascending port), allocation, flush.
  always_comb begin
    values_nx = values;
    rename_nx = rename;
    busy_nx   = busy;
    for (int j = 0; j < CMT_PORTS; j++) begin
      if (cmt_eff[j]) begin
        values_nx[cmt_reg[j*REG_W +: REG_W]] = cmt_value[j*XLEN +: XLEN];
        if (busy[cmt_reg[j*REG_W +: REG_W]] &&
            (rename[cmt_reg[j*REG_W +: REG_W]] == cmt_rob[j*ROB_W +: ROB_W]))
          busy_nx[cmt_reg[j*REG_W +: REG_W]] = FALSE;
      end
    end
    if (alloc_eff) begin
      busy_nx[alloc_reg]   = TRUE;
      rename_nx[alloc_reg] = alloc_rob;
    end
    if (flush) begin
      busy_nx = '0;
      for (int i = 0; i < REG_NUM; i++)
        rename_nx[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        values[i] <= '0;
        rename[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      values   <= values_nx;
      rename   <= rename_nx;
      busy     <= busy_nx;
      busy_cnt <= (REG_W+1)'($countones(busy_nx));
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
    rf_read_port #(
      .XLEN      (XLEN),
      .REG_NUM   (REG_NUM),
      .REG_W     (REG_W),
      .ROB_W     (ROB_W),
      .CMT_PORTS (CMT_PORTS)
    ) u_rd_port (
      .rd_reg    (rd_reg[p*REG_W +: REG_W]),
      .values    (values),
      .rename    (rename),
      .busy      (busy),
`ifdef RF_COMMIT_BYPASS_EN
      .cmt_eff   (cmt_eff),
      .cmt_reg   (cmt_reg),
      .cmt_rob   (cmt_rob),
      .cmt_value (cmt_value),
      .alloc_eff (alloc_eff),
      .alloc_reg (alloc_reg),
`endif
      .rd_value  (rd_value[p*XLEN +: XLEN]),
      .rd_rob    (rd_rob[p*ROB_W +: ROB_W]),
      .rd_busy   (rd_busy[p])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_rat_mp.sv
// ============================================================================
// Module   : tb_regfile_rat_mp
// Brief    : Directed scoreboard bench for regfile_rat_mp
//            (honours RF_COMMIT_BYPASS_EN when defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_rat_mp;
  localparam int XLEN = 32, REG_NUM = 32, REG_W = 5, ROB_W = 4;
  localparam int RD_PORTS = 2, CMT_PORTS = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       rdy;
  logic [RD_PORTS*REG_W-1:0]  rd_reg;
  logic [RD_PORTS*XLEN-1:0]   rd_value;
  logic [RD_PORTS*ROB_W-1:0]  rd_rob;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       alloc_en;
  logic [REG_W-1:0]           alloc_reg;
  logic [ROB_W-1:0]           alloc_rob;
  logic [CMT_PORTS-1:0]       cmt_en;
  logic [CMT_PORTS*REG_W-1:0] cmt_reg;
  logic [CMT_PORTS*ROB_W-1:0] cmt_rob;
  logic [CMT_PORTS*XLEN-1:0]  cmt_value;
  logic                       flush;
  logic [REG_W:0]             busy_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string            tag;
    int               port;
    logic [XLEN-1:0]  value;
    logic [ROB_W-1:0] rob;
    logic             busy;
  } exp_t;
  exp_t sb[$];

  regfile_rat_mp #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .REG_W(REG_W), .ROB_W(ROB_W),
    .RD_PORTS(RD_PORTS), .CMT_PORTS(CMT_PORTS)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_reg(rd_reg), .rd_value(rd_value), .rd_rob(rd_rob), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_rob(alloc_rob),
    .cmt_en(cmt_en), .cmt_reg(cmt_reg), .cmt_rob(cmt_rob), .cmt_value(cmt_value),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    alloc_en = 1'b0; alloc_reg = '0; alloc_rob = '0;
    cmt_en = '0; cmt_reg = '0; cmt_rob = '0; cmt_value = '0;
    flush = 1'b0;
  endtask

  task automatic drive_cmt(input int p, input logic [REG_W-1:0] r,
                           input logic [ROB_W-1:0] t, input logic [XLEN-1:0] v);
    cmt_en[p] = 1'b1;
    cmt_reg[p*REG_W +: REG_W] = r;
    cmt_rob[p*ROB_W +: ROB_W] = t;
    cmt_value[p*XLEN +: XLEN] = v;
  endtask

  task automatic drive_alloc(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t);
    alloc_en = 1'b1; alloc_reg = r; alloc_rob = t;
  endtask

  task automatic exp_rd(input string tag, input int p, input logic [REG_W-1:0] r,
                        input logic [XLEN-1:0] v, input logic [ROB_W-1:0] t,
                        input logic b);
    exp_t e;
    rd_reg[p*REG_W +: REG_W] = r;
    e.tag = tag; e.port = p; e.value = v; e.rob = t; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    logic [XLEN-1:0]  ov;
    logic [ROB_W-1:0] orob;
    logic             ob;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ov = rd_value[e.port*XLEN +: XLEN];
      orob = rd_rob[e.port*ROB_W +: ROB_W];
      ob = rd_busy[e.port];
      compared++;
      assert (ov === e.value) else begin
        mismatched++;
        $error("FAIL %s value: got %h expected %h", e.tag, ov, e.value);
      end
      compared++;
      assert (orob === e.rob) else begin
        mismatched++;
        $error("FAIL %s rob: got %0d expected %0d", e.tag, orob, e.rob);
      end
      compared++;
      assert (ob === e.busy) else begin
        mismatched++;
        $error("FAIL %s busy: got %b expected %b", e.tag, ob, e.busy);
      end
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [REG_W:0] exp);
    compared++;
    assert (busy_cnt === exp) else begin
      mismatched++;
      $error("FAIL %s busy_cnt: got %0d expected %0d", tag, busy_cnt, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rd_reg = '0;
    clear_in();
    #12 rst = 1'b0;

    exp_rd("reset_x5", 0, 5'd5, 32'h0, 4'd0, 1'b0);
    check_rd();
    chk_cnt("reset", 6'd0);

    // allocate x5 -> tag 3
    drive_alloc(5'd5, 4'd3);
    tick(); clear_in();
    exp_rd("alloc_x5", 0, 5'd5, 32'h0, 4'd3, 1'b1);
    check_rd();
    chk_cnt("alloc_x5", 6'd1);

    // commit x5 tag 3; same-cycle read depends on bypass
    drive_cmt(0, 5'd5, 4'd3, 32'hDEAD);
`ifdef RF_COMMIT_BYPASS_EN
    exp_rd("byp_x5", 1, 5'd5, 32'hDEAD, 4'd3, 1'b0);
`else
    exp_rd("nobyp_x5", 1, 5'd5, 32'h0, 4'd3, 1'b1);
`endif
    check_rd();
    tick(); clear_in();
    exp_rd("cmt_x5", 0, 5'd5, 32'hDEAD, 4'd3, 1'b0);
    check_rd();
    chk_cnt("cmt_x5", 6'd0);

    // stale commit on x7
    drive_alloc(5'd7, 4'd2); tick(); clear_in();
    drive_alloc(5'd7, 4'd6); tick(); clear_in();
    drive_cmt(0, 5'd7, 4'd2, 32'h11); tick(); clear_in();
    exp_rd("stale_x7", 0, 5'd7, 32'h11, 4'd6, 1'b1);
    check_rd();
    chk_cnt("stale_x7", 6'd1);

    // dual commit to x9, port 1 wins value, its tag clears busy
    drive_alloc(5'd9, 4'd4); tick(); clear_in();
    chk_cnt("alloc_x9", 6'd2);
    drive_cmt(0, 5'd9, 4'd1, 32'hAA);
    drive_cmt(1, 5'd9, 4'd4, 32'hBB);
    tick(); clear_in();
    exp_rd("dual_x9", 1, 5'd9, 32'hBB, 4'd4, 1'b0);
    check_rd();
    chk_cnt("dual_x9", 6'd1);

    // allocation beats a same-cycle matching commit clear
    drive_alloc(5'd10, 4'd7); tick(); clear_in();
    drive_cmt(0, 5'd10, 4'd7, 32'h55);
    drive_alloc(5'd10, 4'd8);
    tick(); clear_in();
    exp_rd("alloc_ovr_x10", 0, 5'd10, 32'h55, 4'd8, 1'b1);
    check_rd();
    chk_cnt("alloc_ovr", 6'd2);

    // flush beats allocation; commits still write; x0 never written
    drive_alloc(5'd3, 4'd5);
    flush = 1'b1;
    drive_cmt(0, 5'd3, 4'd0, 32'h42);
    drive_cmt(1, 5'd0, 4'd0, 32'hFFFF);
    tick(); clear_in();
    exp_rd("flush_x3", 0, 5'd3, 32'h42, 4'd0, 1'b0);
    exp_rd("flush_x0", 1, 5'd0, 32'h0, 4'd0, 1'b0);
    check_rd();
    exp_rd("flush_x7", 0, 5'd7, 32'h11, 4'd0, 1'b0);
    check_rd();
    chk_cnt("flush", 6'd0);

    // rdy low freezes state
    rdy = 1'b0;
    drive_alloc(5'd12, 4'd1);
    drive_cmt(0, 5'd12, 4'd1, 32'h99);
    tick(); clear_in();
    rdy = 1'b1;
    exp_rd("frozen_x12", 0, 5'd12, 32'h0, 4'd0, 1'b0);
    check_rd();
    chk_cnt("frozen", 6'd0);

    // bypass scenario on x4
    drive_alloc(5'd4, 4'd1); tick(); clear_in();
    chk_cnt("alloc_x4", 6'd1);
    drive_cmt(0, 5'd4, 4'd1, 32'h77);
`ifdef RF_COMMIT_BYPASS_EN
    exp_rd("byp_x4", 1, 5'd4, 32'h77, 4'd1, 1'b0);
`else
    exp_rd("nobyp_x4", 1, 5'd4, 32'h0, 4'd1, 1'b1);
`endif
    check_rd();
    tick(); clear_in();
    exp_rd("cmt_x4", 1, 5'd4, 32'h77, 4'd1, 1'b0);
    check_rd();
    chk_cnt("cmt_x4", 6'd0);

    // asynchronous reset between clock edges
    drive_alloc(5'd5, 4'd2); tick(); clear_in();
    chk_cnt("pre_rst", 6'd1);
    #2 rst = 1'b1;
    exp_rd("async_rst_x5", 0, 5'd5, 32'h0, 4'd0, 1'b0);
    exp_rd("async_rst_x3", 1, 5'd3, 32'h0, 4'd0, 1'b0);
    check_rd();
    chk_cnt("async_rst", 6'd0);
    #2 rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_rat_mp.md
Name: regfile_rat_mp

Overview:
- Parametrised successor to the single-commit architectural register file with rename table.
- Holds architectural values, ROB rename tag and busy bit per register.
- Serves RD_PORTS decoder read ports, one rename allocation per cycle, and CMT_PORTS in-order ROB commits per cycle.
- Sits between decoder/fetcher (reads, allocation), ROB (commit, mispredict flush) and an optional same-cycle commit bypass.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, number of architectural registers; x0 hardwired.
- REG_W, 5, register index width; must satisfy 2^REG_W >= REG_NUM.
- ROB_W, 4, ROB tag width.
- RD_PORTS, 2, number of decoder read ports.
- CMT_PORTS, 2, number of commit ports; port 0 is oldest in program order.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- rd_reg  in  RD_PORTS*REG_W  read indices, flattened; port i is bits [i*REG_W +: REG_W].
- rd_value  out  RD_PORTS*XLEN  read values.
- rd_rob  out  RD_PORTS*ROB_W  rename tags.
- rd_busy  out  RD_PORTS  busy bits.
- alloc_en  in  1  rename-allocate destination.
- alloc_reg  in  REG_W  destination register.
- alloc_rob  in  ROB_W  destination ROB tag.
- cmt_en  in  CMT_PORTS  commit valid per port.
- cmt_reg  in  CMT_PORTS*REG_W  commit destination.
- cmt_rob  in  CMT_PORTS*ROB_W  commit ROB tag.
- cmt_value  in  CMT_PORTS*XLEN  commit value.
- flush  in  1  mispredict flush (xbp).
- busy_cnt  out  REG_W+1  number of busy registers (registered).

Behaviour:
- Reset (async, any time including mid-operation): all values=0, rename=0, busy=0, busy_cnt=0.
- rdy=0: no state changes; reads remain combinational.
- Reads are combinational from the arrays. rd_reg=0 always returns value 0, rob 0, busy 0.
- Commit on port j is effective when cmt_en[j]=1, rdy=1 and cmt_reg[j]!=0. Its effect at the posedge:
  - values[reg] <= cmt_value[j].
  - If busy[reg]=1 and rename[reg]==cmt_rob[j], busy[reg] is cleared.
- Same register on multiple commit ports in one cycle: the highest-index port's value is written. Busy is cleared if any port's tag matches.
- Allocation is effective when alloc_en=1, rdy=1 and alloc_reg!=0: busy<=1, rename<=alloc_rob. It overrides a commit-clear on the same register in the same cycle; the commit value is still written.
- flush=1: all busy<=0 and rename<=0. It overrides allocation. Commits in the same cycle still write values.
- x0 is never written.
- busy_cnt equals the popcount of the next-state busy vector, registered; it updates the cycle after the change.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- With the macro: a read port whose register has an effective commit this cycle returns bypassed data:
  - rd_value = that commit value (highest matching port).
  - rd_busy = 0 if the tag matches rename[reg] and no same-cycle allocation targets that register.
- Without the macro: reads reflect only registered state, so commit data becomes visible one cycle later.

Decomposition:
- Add to definition.v: XLEN/REG/ROB default widths, ZERO_WORD, ZERO_ROB, TRUE/FALSE.
- Sub-module rf_read_port: one port's array lookup, x0 masking and bypass mux. Instantiate it RD_PORTS times via generate.

Test Plan:
- Async reset mid-run: assert rst between clock edges with busy[5]=1 → all outputs 0 immediately, busy_cnt=0.
- Alloc x5→tag 3; commit x5, tag 3, 0xDEAD next cycle → read x5 gives value 0xDEAD, busy 0; busy_cnt goes 1 then 0.
- Stale commit: alloc x7→tag 2, re-alloc x7→tag 6, commit x7 tag 2 value 0x11 → value 0x11 stored, busy stays 1, rob=6.
- Dual commit to x9 (port0 0xAA tag1, port1 0xBB tag4, rename=4) → value 0xBB, busy 0.
- Alloc x3→tag 5 together with flush, plus commit x3 value 0x42 → busy 0, rob 0, value 0x42; writes to x0 read back as 0.
- RF_COMMIT_BYPASS_EN: commit x4 tag 1 value 0x77 while reading x4 (rename 1) → same-cycle rd_value=0x77, rd_busy=0. Without the macro → old value, busy 1.
